// File: rtl/step_controller.sv
// Debug step/run/halt controller gating the CPU clock enable, with PC breakpoints and an optional store watchpoint (STEP_CTRL_WATCH_EN).
// Latency: cpu_en is combinational from state/pc/halt_req; bp_hit, bp_hit_idx and wp_hit are registered pulses one cycle after the stop.
// Backpressure: none; the CPU advances only on edges where cpu_en=1.
module step_controller #(
    parameter int ADDR_W = 32,
    parameter int NUM_BP = 4,
    parameter int CNT_W  = 32,
    parameter int IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              step,
    input  logic              run,
    input  logic              halt_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              bp_wr,
    input  logic [IDX_W-1:0]  bp_idx,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_valid_in,
    input  logic              count_clr,
    input  logic              dmem_we,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [ADDR_W-1:0] watch_addr,
    input  logic              watch_valid,
    output logic              cpu_en,
    output logic              halted,
    output logic              bp_hit,
    output logic [IDX_W-1:0]  bp_hit_idx,
    output logic              wp_hit,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [1:0] {S_HALTED, S_STEP, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] bp_addr_q [NUM_BP];
    logic [ADDR_W-1:0] bp_addr_d [NUM_BP];
    logic [NUM_BP-1:0] bp_valid_q, bp_valid_d;
    logic              first_run_q, first_run_d;
    logic              bp_hit_q, bp_hit_d;
    logic [IDX_W-1:0]  bp_hit_idx_q, bp_hit_idx_d;
    logic              wp_hit_q, wp_hit_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;

    logic              bp_match, bp_match_eff, stop, wp_stop, cpu_en_int;
    logic [IDX_W-1:0]  match_idx;

    // Scan high to low so the lowest matching slot is the one reported.
    always_comb begin
        bp_match  = 1'b0;
        match_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_valid_q[i] && (bp_addr_q[i] == pc)) begin
                bp_match  = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    assign bp_match_eff = bp_match & ~first_run_q;
    assign stop         = halt_req | bp_match_eff;
    assign cpu_en_int   = ~reset & ((state_q == S_STEP) | ((state_q == S_RUN) & ~stop));

`ifdef STEP_CTRL_WATCH_EN
    assign wp_stop = cpu_en_int & watch_valid & dmem_we & (dmem_addr == watch_addr);
`else
    logic watch_unused;
    assign watch_unused = ^{dmem_we, dmem_addr, watch_addr, watch_valid};
    assign wp_stop      = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        first_run_d   = 1'b0;
        bp_hit_d      = (state_q == S_RUN) & bp_match_eff;
        bp_hit_idx_d  = bp_hit_d ? match_idx : bp_hit_idx_q;
        wp_hit_d      = wp_stop;
        bp_addr_d     = bp_addr_q;
        bp_valid_d    = bp_valid_q;
        cycle_count_d = count_clr ? '0 : cycle_count_q + CNT_W'(cpu_en_int);

        case (state_q)
            S_HALTED: begin
                if (step) begin
                    state_d = S_STEP;
                end else if (run) begin
                    state_d     = S_RUN;
                    first_run_d = 1'b1;
                end
            end
            S_STEP:  state_d = S_HALTED;
            S_RUN:   if (stop || wp_stop) state_d = S_HALTED;
            default: state_d = S_HALTED;
        endcase

        if (bp_wr && (32'(bp_idx) < NUM_BP)) begin
            bp_addr_d[bp_idx]  = bp_addr;
            bp_valid_d[bp_idx] = bp_valid_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_HALTED;
            first_run_q   <= 1'b0;
            bp_hit_q      <= 1'b0;
            bp_hit_idx_q  <= '0;
            wp_hit_q      <= 1'b0;
            bp_valid_q    <= '0;
            cycle_count_q <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            first_run_q   <= first_run_d;
            bp_hit_q      <= bp_hit_d;
            bp_hit_idx_q  <= bp_hit_idx_d;
            wp_hit_q      <= wp_hit_d;
            bp_valid_q    <= bp_valid_d;
            cycle_count_q <= cycle_count_d;
            bp_addr_q     <= bp_addr_d;
        end
    end

    assign cpu_en      = cpu_en_int;
    assign halted      = (state_q == S_HALTED);
    assign bp_hit      = bp_hit_q;
    assign bp_hit_idx  = bp_hit_idx_q;
    assign wp_hit      = wp_hit_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller: vector table for step/run/halt/breakpoint flow plus hand sequences.
module tb_step_controller;

    logic        clock = 1'b0;
    logic        reset, step, run, halt_req, bp_wr, bp_valid_in, count_clr;
    logic [2:0]  bp_idx;
    logic [31:0] pc, bp_addr, dmem_addr, watch_addr;
    logic        dmem_we, watch_valid;
    logic        cpu_en, halted, bp_hit, wp_hit;
    logic [2:0]  bp_hit_idx;
    logic [7:0]  cycle_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        step, run, halt_req, count_clr;
        logic [31:0] pc;
        logic        en, hlt, bh;
        logic [2:0]  idx;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    step_controller #(.ADDR_W(32), .NUM_BP(5), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .step(step), .run(run), .halt_req(halt_req), .pc(pc),
        .bp_wr(bp_wr), .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_valid_in(bp_valid_in),
        .count_clr(count_clr), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .watch_addr(watch_addr), .watch_valid(watch_valid), .cpu_en(cpu_en), .halted(halted),
        .bp_hit(bp_hit), .bp_hit_idx(bp_hit_idx), .wp_hit(wp_hit), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int st, input int rn, input int hr, input int cc, input int pcv,
                       input int en, input int h, input int bh, input int idx, input int cnt);
        vec_t v;
        v.step = st[0]; v.run = rn[0]; v.halt_req = hr[0]; v.count_clr = cc[0];
        v.pc = 32'(pcv); v.en = en[0]; v.hlt = h[0]; v.bh = bh[0];
        v.idx = 3'(idx); v.cnt = 8'(cnt);
        vecs.push_back(v);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic drive(input logic st, input logic rn, input logic hr, input logic cc,
                         input logic [31:0] pcv, input logic we, input logic [31:0] da);
        @(posedge clock); #1;
        reset = 1'b0; step = st; run = rn; halt_req = hr; count_clr = cc; pc = pcv;
        bp_wr = 1'b0; dmem_we = we; dmem_addr = da;
        @(negedge clock);
    endtask

    task automatic wr_bp(input logic [2:0] idx, input logic [31:0] addr, input logic v);
        @(posedge clock); #1;
        step = 1'b0; run = 1'b0; halt_req = 1'b0; count_clr = 1'b0;
        bp_wr = 1'b1; bp_idx = idx; bp_addr = addr; bp_valid_in = v;
    endtask

    initial begin
        reset = 1'b1; step = 1'b1; run = 1'b0; halt_req = 1'b0; pc = '0;
        bp_wr = 1'b0; bp_idx = '0; bp_addr = '0; bp_valid_in = 1'b0; count_clr = 1'b0;
        dmem_we = 1'b0; dmem_addr = '0; watch_addr = 32'h54; watch_valid = 1'b0;

        @(negedge clock);
        chk("cpu_en during reset", cpu_en, 0);
        @(negedge clock);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        chk("reset halted", halted, 1);
        chk("reset cycle_count", cycle_count, 0);
        chk("reset bp_hit", bp_hit, 0);
        chk("reset bp_hit_idx", bp_hit_idx, 0);
        chk("reset wp_hit", wp_hit, 0);

        wr_bp(3'd2, 32'h10, 1'b1);
        wr_bp(3'd1, 32'h20, 1'b1);
        wr_bp(3'd3, 32'h20, 1'b1);
        wr_bp(3'd7, 32'h08, 1'b1);
        wr_bp(3'd0, 32'h0C, 1'b1);
        wr_bp(3'd0, 32'h0C, 1'b0);

        //   st rn hr cc  pc     en h bh idx cnt
        add(1, 0, 0, 0, 'h00,  0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 'h00,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 'h00,  0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 'h00,  0, 1, 0, 0, 1);
        add(0, 1, 0, 0, 'h00,  0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 'h00,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 'h04,  1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 'h08,  1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 'h0C,  1, 0, 0, 0, 3);
        add(0, 0, 0, 0, 'h10,  0, 0, 0, 0, 4);
        add(0, 0, 0, 0, 'h10,  0, 1, 1, 2, 4);
        add(0, 0, 0, 0, 'h10,  0, 1, 0, 2, 4);
        add(0, 1, 0, 0, 'h10,  0, 1, 0, 2, 4);
        add(0, 0, 0, 0, 'h10,  1, 0, 0, 2, 4);
        add(0, 0, 0, 0, 'h14,  1, 0, 0, 2, 5);
        add(0, 0, 1, 0, 'h18,  0, 0, 0, 2, 6);
        add(0, 0, 0, 0, 'h18,  0, 1, 0, 2, 6);
        add(1, 1, 0, 0, 'h18,  0, 1, 0, 2, 6);
        add(0, 0, 0, 0, 'h18,  1, 0, 0, 2, 6);
        add(0, 0, 0, 0, 'h18,  0, 1, 0, 2, 7);
        add(0, 1, 0, 0, 'h18,  0, 1, 0, 2, 7);
        add(1, 0, 0, 1, 'h18,  1, 0, 0, 2, 7);
        add(0, 0, 1, 0, 'h1C,  0, 0, 0, 2, 0);
        add(0, 0, 0, 0, 'h1C,  0, 1, 0, 2, 0);
        add(0, 1, 0, 0, 'h1C,  0, 1, 0, 2, 0);
        add(0, 0, 0, 0, 'h1C,  1, 0, 0, 2, 0);
        add(0, 0, 1, 0, 'h20,  0, 0, 0, 2, 1);
        add(0, 0, 0, 0, 'h20,  0, 1, 1, 1, 1);
        add(0, 0, 0, 0, 'h20,  0, 1, 0, 1, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].step, vecs[i].run, vecs[i].halt_req, vecs[i].count_clr, vecs[i].pc, 0, 0);
            chk($sformatf("row%0d cpu_en", i), cpu_en, vecs[i].en);
            chk($sformatf("row%0d halted", i), halted, vecs[i].hlt);
            chk($sformatf("row%0d bp_hit", i), bp_hit, vecs[i].bh);
            chk($sformatf("row%0d bp_hit_idx", i), bp_hit_idx, vecs[i].idx);
            chk($sformatf("row%0d cycle_count", i), cycle_count, vecs[i].cnt);
        end

        // Data-store watchpoint at 0x54 while running.
        watch_valid = 1'b1;
        drive(0, 1, 0, 0, 32'h40, 0, 0);
        chk("wp halted before run", halted, 1);
        drive(0, 0, 0, 0, 32'h40, 1, 32'h50);
        chk("wp other-addr store en", cpu_en, 1);
        drive(0, 0, 0, 0, 32'h44, 1, 32'h54);
        chk("wp store cycle en", cpu_en, 1);
        drive(0, 0, 0, 0, 32'h48, 0, 0);
`ifdef STEP_CTRL_WATCH_EN
        chk("wp stop halted", halted, 1);
        chk("wp_hit pulse", wp_hit, 1);
        chk("wp stop cpu_en", cpu_en, 0);
        drive(0, 0, 0, 0, 32'h48, 0, 0);
        chk("wp_hit single", wp_hit, 0);
        chk("wp still halted", halted, 1);
`else
        chk("wp ignored halted", halted, 0);
        chk("wp ignored wp_hit", wp_hit, 0);
        chk("wp ignored cpu_en", cpu_en, 1);
        drive(0, 0, 1, 0, 32'h48, 0, 0);
        chk("wp ignored halt en", cpu_en, 0);
        chk("wp ignored wp_hit2", wp_hit, 0);
        drive(0, 0, 0, 0, 32'h48, 0, 0);
        chk("wp ignored halted end", halted, 1);
`endif
        watch_valid = 1'b0;

        // Reset asserted in the middle of a run with cycle_count = 7.
        drive(0, 1, 0, 1, 32'h100, 0, 0);
        chk("mid-run start halted", halted, 1);
        for (int k = 0; k < 7; k++) begin
            drive(0, 0, 0, 0, 32'h100 + 32'(4 * k), 0, 0);
            chk($sformatf("mid-run en%0d", k), cpu_en, 1);
        end
        @(posedge clock); #1;
        reset = 1'b1; pc = 32'h11C;
        @(negedge clock);
        chk("reset mid-run cpu_en", cpu_en, 0);
        chk("count before reset", cycle_count, 7);
        drive(0, 0, 0, 0, 32'h10, 0, 0);
        chk("after reset halted", halted, 1);
        chk("after reset count", cycle_count, 0);
        chk("after reset bp_hit_idx", bp_hit_idx, 0);

        // Slots were cleared by reset, so no breakpoint stops; then count wraps at 8 bits.
        drive(0, 1, 0, 0, 32'h10, 0, 0);
        drive(0, 0, 0, 0, 32'h10, 0, 0);
        chk("post-reset first run en", cpu_en, 1);
        drive(0, 0, 0, 0, 32'h20, 0, 0);
        chk("slot1/3 cleared", cpu_en, 1);
        drive(0, 0, 0, 0, 32'h10, 0, 0);
        chk("slot2 cleared", cpu_en, 1);
        for (int k = 0; k < 254; k++) begin
            drive(0, 0, 0, 0, 32'h300, 0, 0);
        end
        chk("long run halted", halted, 0);
        drive(0, 0, 1, 0, 32'h300, 0, 0);
        chk("count wrap", cycle_count, 1);
        chk("wrap halt en", cpu_en, 0);
        drive(0, 0, 0, 0, 32'h300, 0, 0);
        chk("wrap halted", halted, 1);
        chk("halt-only no bp_hit", bp_hit, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
